uart_tx_arbiter: RTL and testbench

Shares the single uart_tx serializer among NUM_REQ byte sources, such as the echo path, the CPU debug port and the loader status.
- Round-robin arbitration on packet boundaries: once granted, a requester keeps the line until it sends a byte flagged last, or until its hold timeout expires.
- Drives the uart_tx i_Tx_DV / i_Tx_Byte pair directly and paces bytes using o_Tx_Active / o_Tx_Done.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter_chk.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;
   localparam int BYTE_W     = 8;
   localparam int MAX_REQ    = 8;
   localparam int IDX_W      = 3;
   localparam int DATA_EXT_W = MAX_REQ * BYTE_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      HOLD      = 2'd3
   } arb_state_e;

   // Byte lane of requester idx from a flattened request data bus.
   function automatic logic [BYTE_W-1:0] req_byte(
      input logic [DATA_EXT_W-1:0] data,
      input logic [IDX_W-1:0]      idx
   );
      return data[idx*BYTE_W +: BYTE_W];
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// the pointer, wrapping past the top index.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     win_onehot_o,
   output logic [PTR_W-1:0] win_idx_o,
   output logic             any_o
);
   logic [PTR_W-1:0] cand_s;
   logic             found_s;

   // Scan upward from the pointer; the first hit wins.
   always_comb begin
      win_onehot_o = '0;
      win_idx_o    = '0;
      found_s      = 1'b0;
      cand_s       = '0;
      for (int k = 0; k < N; k++) begin
         cand_s = PTR_W'((int'(ptr_i) + k) % N);
         if (!found_s && req_i[cand_s]) begin
            found_s              = 1'b1;
            win_idx_o            = cand_s;
            win_onehot_o[cand_s] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      any_o = found_s;
   end
endmodule

// File: rtl/uart_tx_arbiter_chk.sv
// Output invariants of the arbiter: single owner, strobes only for the owner.
module uart_tx_arbiter_chk #(
   parameter int NUM_REQ = 2
) (
   input logic               clk_50M,
   input logic               reset,
   input logic [NUM_REQ-1:0] grant,
   input logic [NUM_REQ-1:0] req_ready,
   input logic               tx_dv
);
   a_grant_onehot: assert property (@(posedge clk_50M) disable iff (reset)
      $onehot0(grant));

   a_dv_has_owner: assert property (@(posedge clk_50M) disable iff (reset)
      tx_dv |-> (grant != '0));

   a_ready_owner_only: assert property (@(posedge clk_50M) disable iff (reset)
      (req_ready != '0) |-> (tx_dv && $onehot(req_ready) && ((req_ready & ~grant) == '0)));

   a_dv_single_pulse: assert property (@(posedge clk_50M) disable iff (reset)
      tx_dv |=> !tx_dv);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte sources.
// Ownership lasts a whole packet: released on the last byte or a hold timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int HOLD_TIMEOUT = 4096,
   parameter int CNT_W        = 16
) (
   input  logic                      clk_50M,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      tx_dv,
   output logic [BYTE_W-1:0]         tx_byte,
   input  logic                      tx_active,
   input  logic                      tx_done,
   output logic                      busy
);
   localparam int               PTR_W      = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tx_dv_q, tx_dv_d;
   logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  pick_onehot_s;
   logic [PTR_W-1:0]    pick_idx_s;
   logic                pick_any_s;
   logic [PTR_W-1:0]    ptr_next_s;
   logic [DATA_EXT_W-1:0] req_data_ext_s;

   assign req_data_ext_s = DATA_EXT_W'(req_data);
   assign ptr_next_s     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i        (req_valid),
      .ptr_i        (ptr_q),
      .win_onehot_o (pick_onehot_s),
      .win_idx_o    (pick_idx_s),
      .any_o        (pick_any_s)
   );

   // Next-state logic; uart_tx has no reset, so a new byte waits for tx_active low.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      tx_byte_d = tx_byte_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any_s && !tx_active) begin
               state_d   = ISSUE;
               owner_d   = pick_idx_s;
               grant_d   = pick_onehot_s;
               tx_byte_d = req_byte(req_data_ext_s, IDX_W'(pick_idx_s));
               last_d    = req_last[pick_idx_s];
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done && last_q) begin
               state_d = IDLE;
               ptr_d   = ptr_next_s;
               grant_d = '0;
            end else if (tx_done) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         HOLD: begin
            // An owner byte beats a timeout that expires in the same cycle.
            if (req_valid[owner_q] && !tx_active) begin
               state_d   = ISSUE;
               tx_byte_d = req_byte(req_data_ext_s, IDX_W'(owner_q));
               last_d    = req_last[owner_q];
            end else if (HOLD_TIMEOUT == 0) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == HOLD_LIMIT) begin
                  state_d = IDLE;
                  ptr_d   = ptr_next_s;
                  grant_d = '0;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
      tx_dv_d     = (state_d == ISSUE);
      req_ready_d = (state_d == ISSUE) ? grant_d : '0;
      busy_d      = (state_d != IDLE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk_50M) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         grant_q     <= '0;
         tx_byte_q   <= '0;
         last_q      <= 1'b0;
         cnt_q       <= '0;
         tx_dv_q     <= 1'b0;
         req_ready_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         tx_byte_q   <= tx_byte_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         tx_dv_q     <= tx_dv_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign grant     = grant_q;
   assign tx_dv     = tx_dv_q;
   assign tx_byte   = tx_byte_q;
   assign busy      = busy_q;

   uart_tx_arbiter_chk #(
      .NUM_REQ (NUM_REQ)
   ) u_chk (
      .clk_50M   (clk_50M),
      .reset     (reset),
      .grant     (grant_q),
      .req_ready (req_ready_q),
      .tx_dv     (tx_dv_q)
   );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: arbiter driving a behavioural uart_tx (100 clocks per bit)
// with a serial receiver decoding the line.
module tb_uart_tx_arbiter;
   localparam int NR  = 2;
   localparam int CPB = 100;

   logic            clk_50M   = 1'b0;
   logic            reset     = 1'b1;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*8-1:0] req_data  = '0;
   logic [NR-1:0]   req_last  = '0;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   grant;
   logic            tx_dv;
   logic [7:0]      tx_byte;
   logic            busy;
   logic            tx_active = 1'b0;
   logic            tx_done   = 1'b0;
   logic            tx_serial = 1'b1;

   int         total    = 0;
   int         bad      = 0;
   logic       chk_hold = 1'b1;
   logic       prev_dv  = 1'b0;
   logic [7:0] rxq[$];
   logic [7:0] exq[$];
   logic [NR-1:0] gq[$];
   logic [NR-1:0] egq[$];

   always #10 clk_50M = ~clk_50M;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .HOLD_TIMEOUT (50),
      .CNT_W        (16)
   ) dut (
      .clk_50M   (clk_50M),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .tx_active (tx_active),
      .tx_done   (tx_done),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural uart_tx: start, 8 data bits LSB first, stop, one cleanup cycle.
   int         m_st  = 0;
   int         m_cnt = 0;
   int         m_bit = 0;
   logic [7:0] m_sh  = '0;
   always @(posedge clk_50M) begin
      tx_done <= 1'b0;
      case (m_st)
         0: begin
            tx_serial <= 1'b1;
            if (tx_dv) begin
               m_sh      <= tx_byte;
               tx_active <= 1'b1;
               m_cnt     <= 0;
               m_bit     <= 0;
               m_st      <= 1;
            end
         end
         1, 2, 3: begin
            tx_serial <= (m_st == 1) ? 1'b0 : (m_st == 2) ? m_sh[m_bit] : 1'b1;
            if (m_cnt < CPB - 1) begin
               m_cnt <= m_cnt + 1;
            end else begin
               m_cnt <= 0;
               if (m_st == 1) begin
                  m_st <= 2;
               end else if (m_st == 2) begin
                  if (m_bit == 7) m_st <= 3;
                  else m_bit <= m_bit + 1;
               end else begin
                  tx_active <= 1'b0;
                  tx_done   <= 1'b1;
                  m_st      <= 4;
               end
            end
         end
         default: m_st <= 0;
      endcase
   end

   // Serial receiver sampling mid-bit.
   initial begin
      logic [7:0] rx_b;
      forever begin
         @(negedge tx_serial);
         repeat (CPB / 2) @(posedge clk_50M);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk_50M);
            rx_b[i] = tx_serial;
         end
         repeat (CPB) @(posedge clk_50M);
         rxq.push_back(rx_b);
      end
   end

   // Per-cycle output invariants, sampled on the falling edge.
   always @(negedge clk_50M) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("ready_vs_dv", 32'(req_ready), tx_dv ? 32'(grant) : 32'd0);
      chk("dv_pulse", 32'(tx_dv & prev_dv), 32'd0);
      prev_dv = tx_dv;
      if (tx_dv) begin
         gq.push_back(grant);
         chk("dv_has_owner", 32'(grant != '0), 32'd1);
      end
      if (tx_done && chk_hold) chk("byte_hold", 32'(tx_byte), 32'(m_sh));
   end

   task automatic send(input int idx, input logic [7:0] b, input logic l, output int n);
      req_valid[idx]       = 1'b1;
      req_data[idx*8 +: 8] = b;
      req_last[idx]        = l;
      n = 0;
      do begin
         @(negedge clk_50M);
         n++;
      end while (!req_ready[idx] && n < 5000);
      req_valid[idx] = 1'b0;
      chk("ready_timeout", 32'(n < 5000), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk_50M);
         n++;
      end while (!tx_done && n < 5000);
      chk("done_timeout", 32'(n < 5000), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk_50M);
         n++;
      end while ((busy || tx_active) && n < 20000);
      chk({tag, "_idle_timeout"}, 32'(n < 20000), 32'd1);
      repeat (4) @(negedge clk_50M);
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_nbytes"}, 32'(rxq.size()), 32'(exq.size()));
      chk({tag, "_ngrants"}, 32'(gq.size()), 32'(egq.size()));
      while (rxq.size() > 0 && exq.size() > 0) chk({tag, "_byte"}, 32'(rxq.pop_front()), 32'(exq.pop_front()));
      while (gq.size() > 0 && egq.size() > 0) chk({tag, "_owner"}, 32'(gq.pop_front()), 32'(egq.pop_front()));
      rxq.delete(); exq.delete(); gq.delete(); egq.delete();
   endtask

   initial begin
      #1_800_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n, k, a, off_g;
      repeat (3) @(negedge clk_50M);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_dv", 32'(tx_dv), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_byte", 32'(tx_byte), 32'd0);
      reset = 1'b0;

      // Single requester; valid in cycle N gives tx_dv in N+1.
      send(0, 8'h41, 1'b1, n);
      chk("t1_latency", 32'(n), 32'd1);
      exq.push_back(8'h41); egq.push_back(2'b01);
      wait_idle("t1");
      chk("t1_grant_released", 32'(grant), 32'd0);
      check_log("t1");

      // Contention with pointer=1: req1 first.
      fork
         send(0, 8'hA0, 1'b1, n);
         send(1, 8'hB1, 1'b1, k);
      join
      exq.push_back(8'hB1); exq.push_back(8'hA0);
      egq.push_back(2'b10); egq.push_back(2'b01);
      wait_idle("t2a");
      check_log("t2a");

      // req1 alone leaves pointer=0, then contention serves req0 first.
      send(1, 8'hC2, 1'b1, n);
      exq.push_back(8'hC2); egq.push_back(2'b10);
      wait_idle("t2c");
      fork
         send(0, 8'hD0, 1'b1, n);
         send(1, 8'hE1, 1'b1, k);
      join
      exq.push_back(8'hD0); exq.push_back(8'hE1);
      egq.push_back(2'b01); egq.push_back(2'b10);
      wait_idle("t2b");
      check_log("t2b");

      // Packet lock: req1 waits for the whole 3-byte packet of req0.
      fork
         begin
            send(0, 8'h10, 1'b0, n);
            send(0, 8'h11, 1'b0, n);
            send(0, 8'h12, 1'b1, n);
         end
         send(1, 8'h55, 1'b1, k);
      join
      exq.push_back(8'h10); exq.push_back(8'h11); exq.push_back(8'h12); exq.push_back(8'h55);
      egq.push_back(2'b01); egq.push_back(2'b01); egq.push_back(2'b01); egq.push_back(2'b10);
      wait_idle("t3");
      check_log("t3");

      // Hold timeout: 50 HOLD cycles, grant drops on the 51st cycle after tx_done.
      fork
         begin
            send(0, 8'h20, 1'b0, n);
            wait_done();
            k = 0;
            do begin
               @(negedge clk_50M);
               k++;
            end while (grant == 2'b01 && k < 200);
            chk("t4_release_cycles", 32'(k), 32'd51);
            chk("t4_release_grant", 32'(grant), 32'd0);
         end
         send(1, 8'h66, 1'b1, a);
      join
      exq.push_back(8'h20); exq.push_back(8'h66);
      egq.push_back(2'b01); egq.push_back(2'b10);
      wait_idle("t4");
      check_log("t4");

      // Timeout tie: owner valid in the 50th HOLD cycle is issued, no release.
      send(0, 8'h30, 1'b0, n);
      wait_done();
      off_g = 0;
      repeat (50) begin
         @(negedge clk_50M);
         if (grant != 2'b01) off_g++;
      end
      send(0, 8'h31, 1'b1, n);
      chk("t5_tie_latency", 32'(n), 32'd1);
      chk("t5_no_release", 32'(off_g), 32'd0);
      exq.push_back(8'h30); exq.push_back(8'h31);
      egq.push_back(2'b01); egq.push_back(2'b01);
      wait_idle("t5");
      check_log("t5");

      // Reset 300 cycles into a frame; next issue waits for tx_active low.
      send(0, 8'h77, 1'b1, n);
      repeat (300) @(negedge clk_50M);
      chk_hold = 1'b0;
      reset    = 1'b1;
      @(negedge clk_50M);
      chk("t6_rst_grant", 32'(grant), 32'd0);
      chk("t6_rst_dv", 32'(tx_dv), 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_byte", 32'(tx_byte), 32'd0);
      reset          = 1'b0;
      req_data[15:8] = 8'h88;
      req_last[1]    = 1'b1;
      req_valid[1]   = 1'b1;
      n = 0;
      a = -1;
      do begin
         @(negedge clk_50M);
         n++;
         if (a < 0 && !tx_active) a = n;
      end while (!req_ready[1] && n < 5000);
      req_valid[1] = 1'b0;
      chk("t6_issue_after_inactive", 32'(n), 32'(a + 1));
      chk_hold = 1'b1;
      exq.push_back(8'h77); exq.push_back(8'h88);
      egq.push_back(2'b01); egq.push_back(2'b10);
      wait_idle("t6");
      check_log("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
